pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/pipe_skid_buf.sv | 44 ++++
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: default field widths,
// the packed control-vector / datapath layouts with bit offsets, and a flush helper.
package pipe_pkg;

  localparam int unsigned CTRL_W_DEF = 35;
  localparam int unsigned DATA_W_DEF = 39;

  // Control vector, MSB first (pc_ld at bit 34 down to rst_ctl at bit 0).
  typedef struct packed {
    logic        pc_ld;
    logic        ir_ld;
    logic        dx_ld;
    logic        dy_ld;
    logic        wb_en;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  imm_sel;
    logic [20:0] misc;
    logic        rst_ctl;
  } ctrl_vec_t;

  localparam int unsigned PC_LD_OFS   = 34;
  localparam int unsigned IR_LD_OFS   = 33;
  localparam int unsigned DX_LD_OFS   = 32;
  localparam int unsigned DY_LD_OFS   = 31;
  localparam int unsigned WB_EN_OFS   = 30;
  localparam int unsigned ALU_OP_OFS  = 26;
  localparam int unsigned MEM_RD_OFS  = 25;
  localparam int unsigned MEM_WR_OFS  = 24;
  localparam int unsigned IMM_SEL_OFS = 22;
  localparam int unsigned MISC_OFS    = 1;
  localparam int unsigned RST_CTL_OFS = 0;

  // Datapath payload, MSB first.
  typedef struct packed {
    logic [7:0] ir;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [4:0] wb_addr;
    logic [9:0] pc;
  } data_vec_t;

  localparam int unsigned IR_OFS      = 31;
  localparam int unsigned DX_OFS      = 23;
  localparam int unsigned DY_OFS      = 15;
  localparam int unsigned WB_ADDR_OFS = 10;
  localparam int unsigned PC_OFS      = 0;

  // Both a flush and an interrupt squash the stage.
  function automatic logic flush_req(input logic nop_i, input logic irq_i);
    return nop_i | irq_i;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Single parking slot that, together with the output register, forms the two-entry
// skid buffer of pipe_stage_reg. Only instantiated when PIPE_SKID_EN is defined.
module pipe_skid_buf #(
  parameter int unsigned CtrlW = 35,
  parameter int unsigned DataW = 39
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic             pop_i,
  input  logic [CtrlW-1:0] ctrl_i,
  input  logic [DataW-1:0] data_i,
  output logic             valid_o,
  output logic [CtrlW-1:0] ctrl_o,
  output logic [DataW-1:0] data_o
);

  logic             valid_q;
  logic [CtrlW-1:0] ctrl_q;
  logic [DataW-1:0] data_q;

  // Park on stall, release on drain; flush empties the slot.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end else if (pop_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush (nop), interrupt flush
// with one-cycle acknowledge, and a saturating bubble counter.
// Build option: define PIPE_SKID_EN for a two-entry skid buffer with registered
// in_ready; otherwise a single entry with combinational in_ready.
module pipe_stage_reg import pipe_pkg::*; #(
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              nop,
  input  logic              interupt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic              int_ack,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              int_ack_q;
  logic [CNT_W-1:0]  bubble_q;
  logic              flush;
  logic              in_fire;

  assign flush = flush_req(nop, interupt);

`ifdef PIPE_SKID_EN
  logic              in_ready_q;
  logic              out_free;
  logic              skid_valid, skid_valid_nxt;
  logic              skid_load, skid_pop;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  assign in_ready  = in_ready_q;
  assign in_fire   = in_valid && in_ready_q;
  assign out_free  = !out_valid_q || out_ready;
  assign skid_load = !flush && !out_free && in_fire;
  assign skid_pop  = !flush && out_free && skid_valid;

  pipe_skid_buf #(
    .CtrlW (CTRL_W),
    .DataW (DATA_W)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (flush),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (skid_valid),
    .ctrl_o  (skid_ctrl),
    .data_o  (skid_data)
  );

  // Next output: a parked beat always drains ahead of new input.
  always_comb begin
    out_valid_d    = out_valid_q;
    ctrl_d         = ctrl_q;
    data_d         = data_q;
    skid_valid_nxt = skid_valid;
    if (flush) begin
      out_valid_d    = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid_d    = 1'b1;
        ctrl_d         = skid_ctrl;
        data_d         = skid_data;
        skid_valid_nxt = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        ctrl_d      = in_ctrl;
        data_d      = in_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_valid_nxt = 1'b1;
    end
  end

  // Registered ready: accept only while the parking slot will be empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= !skid_valid_nxt;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;
  assign in_fire  = in_valid && in_ready;

  // Next output: flush wins, then accept (replaces a draining beat), then drain.
  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    data_d      = data_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      out_valid_d = 1'b1;
      ctrl_d      = in_ctrl;
      data_d      = in_data;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  // Output register; reset overrides flush and any transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      data_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
    end
  end

  // Interrupt acknowledge follows the request level by one cycle; bubble count saturates.
  always_ff @(posedge clk) begin
    if (!rst) begin
      int_ack_q <= 1'b0;
      bubble_q  <= '0;
    end else begin
      int_ack_q <= interupt;
      if (!out_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
        bubble_q <= bubble_q + 1'b1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_ctrl   = out_valid_q ? ctrl_q : '0;
  assign out_data   = data_q;
  assign int_ack    = int_ack_q;
  assign bubble_cnt = bubble_q;

endmodule
